// File: rtl/mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctrl_if
//  Purpose  : Bundles the core-side request/response signals and the byte-wide
//             RAM port of the memory controller.
//  Modports : master - core/RAM side (drives requests and mem_din)
//             slave  - mem_ctrl (drives responses and the RAM address/data)
//  Signals  : ins_req/ins_addr -> ins_ok/ins_ans        instruction fetch
//             data_req/wr/len/addr/wdata -> data_ok/rdata  load/store
//             mem_din (in), mem_dout/mem_a/mem_wr (out)  RAM byte port
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
) ();
    logic              ins_req;
    logic [ADDR_W-1:0] ins_addr;
    logic              ins_ok;
    logic [31:0]       ins_ans;
    logic              data_req;
    logic              data_wr;
    logic [2:0]        data_len;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic              data_ok;
    logic [31:0]       data_rdata;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;

    modport master (
        output ins_req, ins_addr, data_req, data_wr, data_len, data_addr, data_wdata, mem_din,
        input  ins_ok, ins_ans, data_ok, data_rdata, mem_dout, mem_a, mem_wr
    );

    modport slave (
        input  ins_req, ins_addr, data_req, data_wr, data_len, data_addr, data_wdata, mem_din,
        output ins_ok, ins_ans, data_ok, data_rdata, mem_dout, mem_a, mem_wr
    );
endinterface
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctrl
//  Purpose  : Byte-serial memory controller. Serves INS_BYTES-byte instruction
//             fetches and 1/2/4-byte loads/stores over an 8-bit RAM port whose
//             read data arrives the cycle after its address.
//  Ports    : clk        - clock
//             rst        - asynchronous active-low reset
//             rdy        - global ready, low freezes all state
//             Clear_flag - flush: drops fetches and loads, stores still complete
//             bus        - mem_ctrl_if.slave (core requests and RAM port)
//  Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int INS_BYTES = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rdy,
    input  logic      Clear_flag,
    mem_ctrl_if.slave bus
);
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_INS_RD  = 2'd1;
    localparam logic [1:0] c_ST_DATA_RD = 2'd2;
    localparam logic [1:0] c_ST_DATA_WR = 2'd3;
    localparam logic [2:0] c_INS_LEN    = 3'(INS_BYTES);

    logic [1:0]        r_state, w_state_nxt;
    // Current job
    logic [2:0]        r_cnt, r_len;
    logic [ADDR_W-1:0] r_base;
    logic [31:0]       r_wdata, r_buf;
    // Pending request slots
    logic              r_ins_pend, r_dat_pend, r_dat_wr;
    logic [ADDR_W-1:0] r_ins_addr, r_dat_addr;
    logic [2:0]        r_dat_len;
    logic [31:0]       r_dat_wdata;
    // Registered outputs
    logic              r_ins_ok, r_data_ok, r_mem_wr;
    logic [31:0]       r_ins_ans, r_data_rdata;
    logic [7:0]        r_mem_dout;
    logic [ADDR_W-1:0] r_mem_a;

    // Slot contents as seen this edge: a fresh pulse takes effect immediately,
    // and the flush drops a held fetch or load (but never a held store).
    logic              w_ins_avail, w_dat_avail, w_dat_wr;
    logic [ADDR_W-1:0] w_ins_addr, w_dat_addr;
    logic [2:0]        w_dat_len;
    logic [31:0]       w_dat_wdata;

    assign w_ins_avail = bus.ins_req | (r_ins_pend & ~Clear_flag);
    assign w_ins_addr  = bus.ins_req ? bus.ins_addr : r_ins_addr;
    assign w_dat_avail = bus.data_req | (r_dat_pend & ~(Clear_flag & ~r_dat_wr));
    assign w_dat_wr    = bus.data_req ? bus.data_wr    : r_dat_wr;
    assign w_dat_len   = bus.data_req ? bus.data_len   : r_dat_len;
    assign w_dat_addr  = bus.data_req ? bus.data_addr  : r_dat_addr;
    assign w_dat_wdata = bus.data_req ? bus.data_wdata : r_dat_wdata;

    logic w_rd, w_abort, w_rd_done, w_wr_done, w_can_start, w_start_dat, w_start_ins;

    // A read finishes on the edge that captures its last byte (r_cnt == len);
    // a write finishes one edge after its last byte was driven.
    assign w_rd        = (r_state == c_ST_INS_RD) || (r_state == c_ST_DATA_RD);
    assign w_abort     = w_rd & Clear_flag;
    assign w_rd_done   = w_rd & (r_cnt == r_len) & ~Clear_flag;
    assign w_wr_done   = (r_state == c_ST_DATA_WR) && ((r_cnt + 3'd1) == r_len);
    assign w_can_start = (r_state == c_ST_IDLE) | w_rd_done | w_wr_done;
    assign w_start_dat = w_can_start & w_dat_avail;
    assign w_start_ins = w_can_start & ~w_dat_avail & w_ins_avail;

    logic [1:0]        w_byte_idx, w_next_idx;
    logic [ADDR_W-1:0] w_next_addr;
    logic [31:0]       w_merged;

    // r_cnt-1 is the byte arriving on mem_din; r_cnt+1 is the next byte to address.
    assign w_byte_idx  = 2'(r_cnt - 3'd1);
    assign w_next_idx  = 2'(r_cnt + 3'd1);
    assign w_next_addr = r_base + ADDR_W'(r_cnt + 3'd1);

    always_comb begin
        w_merged = r_buf;
        w_merged[{w_byte_idx, 3'b000} +: 8] = bus.mem_din;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else if (rdy) begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = c_ST_IDLE;
        end else if (w_start_dat) begin
            w_state_nxt = w_dat_wr ? c_ST_DATA_WR : c_ST_DATA_RD;
        end else if (w_start_ins) begin
            w_state_nxt = c_ST_INS_RD;
        end else if (w_rd_done || w_wr_done) begin
            w_state_nxt = c_ST_IDLE;
        end
    end

    // ---------------- FSM: outputs / datapath next values ----------------
    logic [2:0]        w_cnt_nxt, w_len_nxt;
    logic [ADDR_W-1:0] w_base_nxt, w_mem_a_nxt;
    logic [31:0]       w_wdata_nxt, w_buf_nxt, w_ins_ans_nxt, w_data_rdata_nxt;
    logic [7:0]        w_mem_dout_nxt;
    logic              w_mem_wr_nxt, w_ins_ok_nxt, w_data_ok_nxt;

    always_comb begin
        w_cnt_nxt        = r_cnt;
        w_len_nxt        = r_len;
        w_base_nxt       = r_base;
        w_wdata_nxt      = r_wdata;
        w_buf_nxt        = r_buf;
        w_mem_a_nxt      = r_mem_a;
        w_mem_dout_nxt   = r_mem_dout;
        w_mem_wr_nxt     = 1'b0;
        w_ins_ok_nxt     = 1'b0;
        w_ins_ans_nxt    = r_ins_ans;
        w_data_ok_nxt    = 1'b0;
        w_data_rdata_nxt = r_data_rdata;

        case (r_state)
            c_ST_INS_RD, c_ST_DATA_RD: begin
                if (!Clear_flag) begin
                    w_cnt_nxt = r_cnt + 3'd1;
                    if (r_cnt != 3'd0) begin
                        w_buf_nxt = w_merged;
                    end
                    if ((r_cnt + 3'd1) < r_len) begin
                        w_mem_a_nxt = w_next_addr;
                    end
                    if (w_rd_done) begin
                        if (r_state == c_ST_INS_RD) begin
                            w_ins_ok_nxt  = 1'b1;
                            w_ins_ans_nxt = w_merged;
                        end else begin
                            w_data_ok_nxt    = 1'b1;
                            w_data_rdata_nxt = w_merged;
                        end
                    end
                end
            end
            c_ST_DATA_WR: begin
                w_cnt_nxt = r_cnt + 3'd1;
                if (w_wr_done) begin
                    w_data_ok_nxt = 1'b1;
                end else begin
                    w_mem_wr_nxt   = 1'b1;
                    w_mem_a_nxt    = w_next_addr;
                    w_mem_dout_nxt = r_wdata[{w_next_idx, 3'b000} +: 8];
                end
            end
            default: ;
        endcase

        // A new job overrides the idle/finish defaults on the same edge.
        if (w_start_dat) begin
            w_cnt_nxt   = 3'd0;
            w_len_nxt   = w_dat_len;
            w_base_nxt  = w_dat_addr;
            w_wdata_nxt = w_dat_wdata;
            w_buf_nxt   = 32'd0;
            w_mem_a_nxt = w_dat_addr;
            if (w_dat_wr) begin
                w_mem_wr_nxt   = 1'b1;
                w_mem_dout_nxt = w_dat_wdata[7:0];
            end
        end else if (w_start_ins) begin
            w_cnt_nxt   = 3'd0;
            w_len_nxt   = c_INS_LEN;
            w_base_nxt  = w_ins_addr;
            w_buf_nxt   = 32'd0;
            w_mem_a_nxt = w_ins_addr;
        end
    end

    // ---------------- Datapath and request-slot registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt        <= 3'd0;
            r_len        <= 3'd0;
            r_base       <= '0;
            r_wdata      <= 32'd0;
            r_buf        <= 32'd0;
            r_mem_a      <= '0;
            r_mem_dout   <= 8'd0;
            r_mem_wr     <= 1'b0;
            r_ins_ok     <= 1'b0;
            r_ins_ans    <= 32'd0;
            r_data_ok    <= 1'b0;
            r_data_rdata <= 32'd0;
            r_ins_pend   <= 1'b0;
            r_ins_addr   <= '0;
            r_dat_pend   <= 1'b0;
            r_dat_wr     <= 1'b0;
            r_dat_len    <= 3'd0;
            r_dat_addr   <= '0;
            r_dat_wdata  <= 32'd0;
        end else if (rdy) begin
            r_cnt        <= w_cnt_nxt;
            r_len        <= w_len_nxt;
            r_base       <= w_base_nxt;
            r_wdata      <= w_wdata_nxt;
            r_buf        <= w_buf_nxt;
            r_mem_a      <= w_mem_a_nxt;
            r_mem_dout   <= w_mem_dout_nxt;
            r_mem_wr     <= w_mem_wr_nxt;
            r_ins_ok     <= w_ins_ok_nxt;
            r_ins_ans    <= w_ins_ans_nxt;
            r_data_ok    <= w_data_ok_nxt;
            r_data_rdata <= w_data_rdata_nxt;
            r_ins_pend   <= w_ins_avail & ~w_start_ins;
            r_ins_addr   <= w_ins_addr;
            r_dat_pend   <= w_dat_avail & ~w_start_dat;
            r_dat_wr     <= w_dat_wr;
            r_dat_len    <= w_dat_len;
            r_dat_addr   <= w_dat_addr;
            r_dat_wdata  <= w_dat_wdata;
        end
    end

    assign bus.ins_ok     = r_ins_ok;
    assign bus.ins_ans    = r_ins_ans;
    assign bus.data_ok    = r_data_ok;
    assign bus.data_rdata = r_data_rdata;
    assign bus.mem_a      = r_mem_a;
    assign bus.mem_dout   = r_mem_dout;
    assign bus.mem_wr     = r_mem_wr;
endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_mem_ctrl
//  Purpose  : Directed self-checking bench for mem_ctrl with a byte RAM model
//             (read data registered one cycle after its address).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic rst, rdy, Clear_flag;
    int   total = 0;
    int   bad   = 0;

    mem_ctrl_if #(.ADDR_W(32)) bus ();

    mem_ctrl #(.ADDR_W(32), .INS_BYTES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .Clear_flag (Clear_flag),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // RAM model: 64 KiB, indexed by the low address bits so wrap-around aliases.
    logic [7:0]  ram [0:65535];
    logic        poke_en = 1'b0;
    logic [15:0] poke_a  = 16'd0;
    logic [7:0]  poke_d  = 8'd0;

    always @(posedge clk) begin
        bus.mem_din <= ram[bus.mem_a[15:0]];
        if (bus.mem_wr) ram[bus.mem_a[15:0]] <= bus.mem_dout;
        else if (poke_en) ram[poke_a] <= poke_d;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        poke_en = 1'b1; poke_a = a; poke_d = d;
        tick();
        poke_en = 1'b0;
    endtask

    task automatic poke32(input logic [15:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            poke(a + 16'(i), w[8*i +: 8]);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req_ins(input logic [31:0] a);
        bus.ins_req = 1'b1; bus.ins_addr = a;
    endtask

    task automatic req_data(input logic wr, input logic [2:0] len,
                            input logic [31:0] a, input logic [31:0] wd);
        bus.data_req = 1'b1; bus.data_wr = wr; bus.data_len = len;
        bus.data_addr = a; bus.data_wdata = wd;
    endtask

    task automatic drop_reqs();
        bus.ins_req = 1'b0; bus.data_req = 1'b0;
    endtask

    int okcnt;

    initial begin
        rst = 1'b0; rdy = 1'b1; Clear_flag = 1'b0;
        bus.ins_req = 1'b0; bus.ins_addr = 32'd0;
        bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.data_len = 3'd0;
        bus.data_addr = 32'd0; bus.data_wdata = 32'd0;
        bus.mem_din = 8'd0;

        // ---- Reset values ----
        repeat (2) tick();
        chk("rst_ins_ok",  32'(bus.ins_ok),   32'd0);
        chk("rst_data_ok", 32'(bus.data_ok),  32'd0);
        chk("rst_mem_wr",  32'(bus.mem_wr),   32'd0);
        chk("rst_mem_a",   bus.mem_a,         32'd0);
        chk("rst_ins_ans", bus.ins_ans,       32'd0);
        chk("rst_rdata",   bus.data_rdata,    32'd0);
        chk("rst_dout",    32'(bus.mem_dout), 32'd0);
        rst = 1'b1;

        poke32(16'h0000, 32'h0000_0013);
        poke32(16'h0010, 32'h1234_5678);
        poke32(16'h1000, 32'hDEAD_BEEF);
        poke(16'hFFFF, 8'hAA);
        poke(16'h2002, 8'h5A);
        poke32(16'h3000, 32'h0000_0000);
        poke32(16'h4000, 32'h7777_7777);

        // ---- 1: instruction fetch at 0x0 ----
        req_ins(32'h0); tick(); drop_reqs();           // edge 0
        chk("f_a0", bus.mem_a, 32'h0);
        chk("f_wr0", 32'(bus.mem_wr), 32'd0);
        tick(); chk("f_a1", bus.mem_a, 32'h1);
        tick(); chk("f_a2", bus.mem_a, 32'h2);
        tick(); chk("f_a3", bus.mem_a, 32'h3);
        tick(); chk("f_ok4", 32'(bus.ins_ok), 32'd0);
        tick(); chk("f_ok5", 32'(bus.ins_ok), 32'd1);
        chk("f_ans", bus.ins_ans, 32'h0000_0013);
        tick(); chk("f_ok6", 32'(bus.ins_ok), 32'd0);

        // ---- 2: LW 0x1000 then LB 0x1003 ----
        req_data(1'b0, 3'd4, 32'h1000, 32'h0); tick(); drop_reqs();
        chk("lw_a0", bus.mem_a, 32'h1000);
        tick(); chk("lw_a1", bus.mem_a, 32'h1001);
        tick(); chk("lw_a2", bus.mem_a, 32'h1002);
        tick(); chk("lw_a3", bus.mem_a, 32'h1003);
        tick(); chk("lw_ok4", 32'(bus.data_ok), 32'd0);
        tick(); chk("lw_ok5", 32'(bus.data_ok), 32'd1);
        chk("lw_rdata", bus.data_rdata, 32'hDEAD_BEEF);
        req_data(1'b0, 3'd1, 32'h1003, 32'h0); tick(); drop_reqs();
        chk("lb_ok_clr", 32'(bus.data_ok), 32'd0);
        chk("lb_a0", bus.mem_a, 32'h1003);
        tick(); chk("lb_ok1", 32'(bus.data_ok), 32'd0);
        tick(); chk("lb_ok2", 32'(bus.data_ok), 32'd1);
        chk("lb_rdata", bus.data_rdata, 32'h0000_00DE);

        // ---- address wrap: LH 0xFFFFFFFF ----
        req_data(1'b0, 3'd2, 32'hFFFF_FFFF, 32'h0); tick(); drop_reqs();
        chk("wrap_a0", bus.mem_a, 32'hFFFF_FFFF);
        tick(); chk("wrap_a1", bus.mem_a, 32'h0000_0000);
        tick(); chk("wrap_ok2", 32'(bus.data_ok), 32'd0);
        tick(); chk("wrap_ok3", 32'(bus.data_ok), 32'd1);
        chk("wrap_rdata", bus.data_rdata, 32'h0000_13AA);

        // ---- 3: SH 0x2000 ----
        req_data(1'b1, 3'd2, 32'h2000, 32'hABCD_1234); tick(); drop_reqs();
        chk("sh_wr0", 32'(bus.mem_wr), 32'd1);
        chk("sh_a0", bus.mem_a, 32'h2000);
        chk("sh_d0", 32'(bus.mem_dout), 32'h34);
        tick();
        chk("sh_wr1", 32'(bus.mem_wr), 32'd1);
        chk("sh_a1", bus.mem_a, 32'h2001);
        chk("sh_d1", 32'(bus.mem_dout), 32'h12);
        chk("sh_ok1", 32'(bus.data_ok), 32'd0);
        tick();
        chk("sh_ok2", 32'(bus.data_ok), 32'd1);
        chk("sh_wr2", 32'(bus.mem_wr), 32'd0);
        tick();
        chk("sh_ok3", 32'(bus.data_ok), 32'd0);
        chk("sh_wr3", 32'(bus.mem_wr), 32'd0);
        chk("sh_ram", {8'h0, ram[16'h2002], ram[16'h2001], ram[16'h2000]}, 32'h005A_1234);

        // ---- 4: simultaneous fetch and load: data first ----
        req_ins(32'h0); req_data(1'b0, 3'd4, 32'h1000, 32'h0); tick(); drop_reqs();
        chk("both_a0", bus.mem_a, 32'h1000);
        repeat (4) tick();                               // edges 1..4
        tick();                                          // edge 5
        chk("both_dok", 32'(bus.data_ok), 32'd1);
        chk("both_rdata", bus.data_rdata, 32'hDEAD_BEEF);
        chk("both_ins_a0", bus.mem_a, 32'h0);
        tick(); chk("both_ins_a1", bus.mem_a, 32'h1);
        repeat (3) tick();                               // edges 7..9
        chk("both_iok9", 32'(bus.ins_ok), 32'd0);
        tick();                                          // edge 10
        chk("both_iok10", 32'(bus.ins_ok), 32'd1);
        chk("both_ans", bus.ins_ans, 32'h0000_0013);
        tick();

        // ---- 5a: flush at edge 3 of a fetch ----
        req_ins(32'h10); tick(); drop_reqs();            // edge 0
        repeat (2) tick();                               // edges 1,2
        Clear_flag = 1'b1;
        okcnt = 0;
        for (int i = 0; i < 6; i++) begin                // edges 3..8
            tick();
            Clear_flag = 1'b0;
            if (bus.ins_ok) okcnt++;
        end
        chk("flush_no_ok", 32'(okcnt), 32'd0);
        req_data(1'b0, 3'd1, 32'h1000, 32'h0); tick(); drop_reqs();
        tick(); tick();
        chk("flush_idle_ok", 32'(bus.data_ok), 32'd1);
        chk("flush_idle_rd", bus.data_rdata, 32'h0000_00EF);

        // ---- 5b: flush during SW: store completes ----
        req_data(1'b1, 3'd4, 32'h3000, 32'h1122_3344); tick(); drop_reqs();
        chk("sw_d0", 32'(bus.mem_dout), 32'h44);
        Clear_flag = 1'b1;
        tick();
        chk("sw_wr1", 32'(bus.mem_wr), 32'd1);
        chk("sw_a1", bus.mem_a, 32'h3001);
        tick();
        Clear_flag = 1'b0;
        tick();
        chk("sw_a3", bus.mem_a, 32'h3003);
        chk("sw_d3", 32'(bus.mem_dout), 32'h11);
        tick();
        chk("sw_ok4", 32'(bus.data_ok), 32'd1);
        chk("sw_wr4", 32'(bus.mem_wr), 32'd0);
        chk("sw_ram", {ram[16'h3003], ram[16'h3002], ram[16'h3001], ram[16'h3000]}, 32'h1122_3344);

        // ---- 6a: rdy low for three cycles mid-fetch ----
        req_ins(32'h10); tick(); drop_reqs();            // edge 0
        repeat (4) tick();                               // edges 1..4
        rdy = 1'b0;
        okcnt = 0;
        for (int i = 0; i < 3; i++) begin                // frozen edges 5..7
            tick();
            if (bus.ins_ok) okcnt++;
        end
        chk("rdy_no_ok", 32'(okcnt), 32'd0);
        rdy = 1'b1;
        tick();                                          // edge 8
        chk("rdy_ok8", 32'(bus.ins_ok), 32'd1);
        chk("rdy_ans", bus.ins_ans, 32'h1234_5678);
        tick();
        chk("rdy_ok9", 32'(bus.ins_ok), 32'd0);

        // ---- 6b: reset mid-write ----
        req_data(1'b1, 3'd4, 32'h4000, 32'hAABB_CCDD); tick(); drop_reqs();
        tick();
        chk("rw_wr1", 32'(bus.mem_wr), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rw_wr_async", 32'(bus.mem_wr), 32'd0);
        chk("rw_a_async", bus.mem_a, 32'd0);
        okcnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.data_ok) okcnt++;
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.data_ok) okcnt++;
        end
        chk("rw_no_ok", 32'(okcnt), 32'd0);
        chk("rw_ram", {ram[16'h4002], ram[16'h4001], ram[16'h4000]}, 32'h0077_77DD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
